// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one uart_tx byte channel to one requester for a whole message.
// Define UART_ARB_ID_HEADER_EN to prefix every message with the byte HEADER_BASE | id.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] HEADER_BASE = 8'hA0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          abort
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_n_s;
  logic [NUM_REQ-1:0]      grant_r;
  logic [IDW-1:0]          id_r;
  logic [IDW-1:0]          last_id_r;
  logic [CW-1:0]           cnt_r;
  logic                    busy_r;
  logic                    abort_r;

  logic                    pick_found_s;
  logic [IDW-1:0]          pick_id_s;
  logic [IDW-1:0]          cand_s;
  logic                    tx_valid_s;
  logic [DATA_WIDTH-1:0]   tx_data_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [DATA_WIDTH-1:0]   hdr_byte_s;
  logic                    hs_s;
  logic                    stall_s;
  logic                    timeout_s;
  logic                    start_s;

  assign hdr_byte_s = HEADER_BASE | DATA_WIDTH'(id_r);
  assign hs_s       = tx_valid_s & tx_ready;
  assign stall_s    = (state_r == ST_STREAM) & ~req_valid[id_r];
  assign timeout_s  = TO_EN && stall_s && (cnt_r == CNT_LAST);
  assign start_s    = (state_r == ST_IDLE) && (state_n_s != ST_IDLE);

  // Round-robin pick: scan downward so the nearest candidate after last_id wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s       = IDW'((int'(last_id_r) + k) % NUM_REQ);
      pick_found_s = pick_found_s | req_valid[cand_s];
      pick_id_s    = req_valid[cand_s] ? cand_s : pick_id_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else if (ena) begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic; handshakes already include ena through tx_valid_s.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ena && pick_found_s) begin
`ifdef UART_ARB_ID_HEADER_EN
          state_n_s = ST_HDR;
`else
          state_n_s = ST_STREAM;
`endif
        end else begin
          state_n_s = state_r;
        end
      end
      ST_HDR: begin
        if (hs_s) begin
          state_n_s = ST_STREAM;
        end else begin
          state_n_s = state_r;
        end
      end
      ST_STREAM: begin
        if (hs_s && req_last[id_r]) begin
          state_n_s = ST_IDLE;
        end else if (ena && timeout_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Channel outputs: header byte or combinational pass-through of the owner.
  always_comb begin
    tx_valid_s  = 1'b0;
    tx_data_s   = '0;
    req_ready_s = '0;
    case (state_r)
      ST_HDR: begin
        tx_valid_s = ena;
        tx_data_s  = ena ? hdr_byte_s : '0;
      end
      ST_STREAM: begin
        tx_valid_s         = ena & req_valid[id_r];
        tx_data_s          = tx_valid_s ? req_data[int'(id_r)*DATA_WIDTH +: DATA_WIDTH] : '0;
        req_ready_s[id_r]  = ena & tx_ready;
      end
      default: begin
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // Grant, owner id, round-robin pointer, stall counter and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_r   <= '0;
      id_r      <= '0;
      last_id_r <= IDW'(NUM_REQ - 1);
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      abort_r   <= 1'b0;
    end else if (ena) begin
      busy_r  <= (state_n_s != ST_IDLE);
      abort_r <= (state_r == ST_STREAM) && timeout_s;
      if (start_s) begin
        grant_r <= NUM_REQ'(1) << pick_id_s;
        id_r    <= pick_id_s;
      end else if ((state_r == ST_STREAM) && (state_n_s == ST_IDLE)) begin
        grant_r   <= '0;
        last_id_r <= id_r;
      end
      // Counter saturates at TIMEOUT_CYCLES; only an empty owner counts, not backpressure.
      if (start_s || hs_s) begin
        cnt_r <= '0;
      end else if (TO_EN && stall_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      abort_r <= 1'b0;
    end
  end

  assign tx_valid  = tx_valid_s;
  assign tx_data   = tx_data_s;
  assign req_ready = req_ready_s;
  assign grant     = grant_r;
  assign busy      = busy_r;
  assign abort     = abort_r & ena;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16); follows UART_ARB_ID_HEADER_EN if defined.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ena;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        abort;

  int checks = 0;
  int errors = 0;
  int order [6] = '{3, 0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16),
    .HEADER_BASE(8'hA0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ena(ena),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy),
    .abort(abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d, input logic l);
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  // First cycle after arbitration: owner registered, header sent when enabled.
  task automatic grant_step(input string tag, input int id);
    #1;
    chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << id));
    chk({tag, "_busy"}, 32'(busy), 32'h1);
`ifdef UART_ARB_ID_HEADER_EN
    chk({tag, "_hdr_v"}, 32'(tx_valid), 32'h1);
    chk({tag, "_hdr_d"}, 32'(tx_data), 32'(8'hA0 | 8'(id)));
    chk({tag, "_hdr_rdy"}, 32'(req_ready), 32'h0);
    tick();
`endif
  endtask

  // One accepted payload byte with tx_ready high.
  task automatic byte_step(input string tag, input logic [7:0] d, input logic [3:0] g);
    #1;
    chk({tag, "_v"}, 32'(tx_valid), 32'h1);
    chk({tag, "_d"}, 32'(tx_data), 32'(d));
    chk({tag, "_g"}, 32'(grant), 32'(g));
    chk({tag, "_rdy"}, 32'(req_ready), 32'(g));
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    ena       = 1'b1;
    tx_ready  = 1'b1;
    req_valid = 4'h0;
    req_last  = 4'h0;
    req_data  = 32'h0;
    #12;
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_txd", 32'(tx_data), 32'h0);
    chk("rst_rdy", 32'(req_ready), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_abort", 32'(abort), 32'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Single 3-byte message from requester 2.
    set_byte(2, 8'h11, 1'b0);
    req_valid = 4'b0100;
    tick();
    grant_step("t1", 2);
    byte_step("t1_b0", 8'h11, 4'b0100);
    set_byte(2, 8'h22, 1'b0);
    byte_step("t1_b1", 8'h22, 4'b0100);
    set_byte(2, 8'h33, 1'b1);
    byte_step("t1_b2", 8'h33, 4'b0100);
    req_valid = 4'h0;
    req_last  = 4'h0;
    #1;
    chk("t1_end_busy", 32'(busy), 32'h0);
    chk("t1_end_grant", 32'(grant), 32'h0);
    chk("t1_end_txv", 32'(tx_valid), 32'h0);
    chk("t1_end_txd", 32'(tx_data), 32'h0);
    tick();

    // All four hold 1-byte messages; pointer starts after requester 2.
    req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    req_last  = 4'hF;
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_bubble_grant", 32'(grant), 32'h0);
      chk("t2_bubble_txv", 32'(tx_valid), 32'h0);
      tick();
      grant_step("t2", order[i]);
      byte_step("t2_b", 8'hC0 | 8'(order[i]), 4'(4'b0001 << order[i]));
    end
    req_valid = 4'h0;
    req_last  = 4'h0;

    // Backpressure for 20 cycles on requester 1.
    set_byte(1, 8'h5A, 1'b0);
    req_valid = 4'b0010;
    tick();
    grant_step("t3", 1);
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_bp_txv", 32'(tx_valid), 32'h1);
      chk("t3_bp_txd", 32'(tx_data), 32'h5A);
      chk("t3_bp_abort", 32'(abort), 32'h0);
      chk("t3_bp_rdy", 32'(req_ready), 32'h0);
      tick();
    end
    tx_ready = 1'b1;
    byte_step("t3_b0", 8'h5A, 4'b0010);
    set_byte(1, 8'hA5, 1'b1);
    byte_step("t3_b1", 8'hA5, 4'b0010);
    req_valid = 4'h0;
    req_last  = 4'h0;

    // Requester 1 stalls mid-message; requester 2 waits behind it.
    set_byte(1, 8'h77, 1'b0);
    req_valid = 4'b0010;
    tick();
    grant_step("t4", 1);
    byte_step("t4_b0", 8'h77, 4'b0010);
    set_byte(2, 8'h99, 1'b1);
    req_valid = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t4_wait_abort", 32'(abort), 32'h0);
      chk("t4_wait_busy", 32'(busy), 32'h1);
      chk("t4_wait_txv", 32'(tx_valid), 32'h0);
      tick();
    end
    #1;
    chk("t4_abort", 32'(abort), 32'h1);
    chk("t4_abort_busy", 32'(busy), 32'h0);
    chk("t4_abort_grant", 32'(grant), 32'h0);
    tick();
    #1;
    chk("t4_abort_low", 32'(abort), 32'h0);
    grant_step("t4_next", 2);
    byte_step("t4_b1", 8'h99, 4'b0100);
    req_valid = 4'h0;
    req_last  = 4'h0;

    // ena low for 5 cycles in the middle of a message from requester 3.
    set_byte(3, 8'h31, 1'b0);
    req_valid = 4'b1000;
    tick();
    grant_step("t5", 3);
    byte_step("t5_b0", 8'h31, 4'b1000);
    set_byte(3, 8'h32, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_off_txv", 32'(tx_valid), 32'h0);
      chk("t5_off_txd", 32'(tx_data), 32'h0);
      chk("t5_off_rdy", 32'(req_ready), 32'h0);
      chk("t5_off_grant", 32'(grant), 32'h8);
      tick();
    end
    ena = 1'b1;
    byte_step("t5_b1", 8'h32, 4'b1000);
    set_byte(3, 8'h33, 1'b1);
    byte_step("t5_b2", 8'h33, 4'b1000);
    req_valid = 4'h0;
    req_last  = 4'h0;

    // Reset mid-message; requesters 0 and 1 then compete and 0 must win.
    set_byte(1, 8'h41, 1'b0);
    req_valid = 4'b0010;
    tick();
    grant_step("t6", 1);
    byte_step("t6_b0", 8'h41, 4'b0010);
    set_byte(0, 8'hE0, 1'b1);
    req_valid = 4'b0011;
    reset_n   = 1'b0;
    #1;
    chk("t6_rst_txv", 32'(tx_valid), 32'h0);
    chk("t6_rst_txd", 32'(tx_data), 32'h0);
    chk("t6_rst_rdy", 32'(req_ready), 32'h0);
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_abort", 32'(abort), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    grant_step("t6_after", 0);
    byte_step("t6_b1", 8'hE0, 4'b0001);
    req_valid = 4'h0;
    req_last  = 4'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `uart_tx` byte channel among `NUM_REQ` requesters at message granularity. Grant is round-robin, held from the first byte of a message until its `last` byte is accepted or the granted requester stalls past a timeout. Sits between on-chip message sources (status reporter, debug dump, command responder) and the `tx_data`/`tx_valid`/`tx_ready` port of the `uart` wrapper.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width; must match the `uart` instance.
- `TIMEOUT_CYCLES`, 1024: idle-stall cycles before a held grant is revoked; 0 disables the timeout.
- `HEADER_BASE`, 8'hA0: header byte base. Used only with `UART_ARB_ID_HEADER_EN`.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ena` in 1: enable. Low freezes all state.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_last` in `NUM_REQ`: marks the final byte of a message; qualified by `req_valid`.
- `req_ready` out `NUM_REQ`: per-requester byte accepted.
- `tx_data` out `DATA_WIDTH`: to `uart.tx_data`.
- `tx_valid` out 1: to `uart.tx_valid`.
- `tx_ready` in 1: from `uart.tx_ready`.
- `grant` out `NUM_REQ`: registered one-hot owner. All zero when idle.
- `busy` out 1: a grant is held.
- `abort` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- State `IDLE`:
  - `tx_valid`=0, `req_ready`=0.
  - If any `req_valid` is set, pick the first set bit, searching upward from `(last_id+1) mod NUM_REQ`.
  - Register `grant` and `id`, clear the timeout counter, then go to `HDR` (macro on) or `STREAM`.
- State `HDR`:
  - `tx_data` = `HEADER_BASE | id`, `tx_valid`=1, `req_ready`=0.
  - On `tx_ready` go to `STREAM`.
- State `STREAM`, combinational pass-through from the granted requester:
  - `tx_data` = `req_data[id]`.
  - `tx_valid` = `req_valid[id]`.
  - `req_ready[id]` = `tx_ready`; all other `req_ready` bits are 0.
- A handshake is `tx_valid & tx_ready`.
  - Handshake with `req_last[id]`: go to `IDLE`, `last_id` ← `id`.
  - Any handshake clears the timeout counter.
- Timeout (`TIMEOUT_CYCLES`≠0):
  - The counter increments on each `STREAM` cycle with `req_valid[id]`=0.
  - Backpressure (`tx_valid`=1, `tx_ready`=0) does not count.
  - When the counter reaches `TIMEOUT_CYCLES`: pulse `abort`, go to `IDLE`, `last_id` ← `id`. The rest of that message is not forwarded.
  - The counter saturates and is sized `$clog2(TIMEOUT_CYCLES+1)`.
- Non-granted requesters are never acknowledged. Their `req_valid` may stay high indefinitely.
- `tx_data` = 0 whenever `tx_valid` = 0.
- `ena`=0:
  - Force `tx_valid`=0, `req_ready`=0, `abort`=0.
  - Hold state, `grant`, `last_id` and the counter.
  - A `tx_ready` seen while `ena`=0 is ignored.

## Timing
- Reset values:
  - `tx_valid`=0, `tx_data`=0, `req_ready`=0, `grant`=0, `busy`=0, `abort`=0.
  - State `IDLE`, `last_id`=`NUM_REQ-1`, so requester 0 wins first.
- Arbitration latency: `req_valid` high in `IDLE` at edge N gives `grant`/`busy` at N+1.
  - First `tx_valid` is asserted in cycle N+1: the header with the macro on, payload without it.
- A message of L payload bytes occupies at least L handshake cycles, plus 1 header handshake if the macro is on.
- There is exactly one `IDLE` bubble cycle between consecutive messages, including same-requester back-to-back messages.
- `busy` = state≠`IDLE` (registered).
- `abort` is asserted in the cycle the state returns to `IDLE`.
- Simultaneous requests: round-robin order only; there are no fixed priorities after the first grant.
- `req_valid` and `req_last` on the last byte, with `tx_ready` low, hold the grant until accepted.
- `reset_n` assertion mid-message: all outputs go to reset values immediately. A partial byte already handed to `uart_tx` is that module's concern.

## Configuration
- `UART_ARB_ID_HEADER_EN` defined: `HDR` state present; every message is prefixed by one byte `HEADER_BASE | id`.
- Not defined: `HDR` state and `HEADER_BASE` are unused; first payload byte follows the grant directly.

## Test plan
- Single message, `NUM_REQ`=4:
  - Stimulus: requester 2 sends 3 bytes 0x11, 0x22, 0x33 (`last` on 0x33), `tx_ready` always 1.
  - Response: `tx_data` sequence 0x11, 0x22, 0x33, preceded by 0xA2 if the macro is on.
  - `grant`=4'b0100 for the whole message, then `busy` falls.
- Round-robin fairness:
  - Stimulus: all four requesters hold 1-byte messages continuously.
  - Response: grant order 0, 1, 2, 3, 0, … with exactly one idle cycle between messages.
- Backpressure:
  - Stimulus: `tx_ready` low for 20 cycles mid-message.
  - Response: `tx_data`/`tx_valid` stable, no `abort`, no byte lost or duplicated.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16; requester 1 sends one byte without `last`, then drops `req_valid`.
  - Response: `abort` pulses 16 cycles after the last handshake; requester 2, pending, is granted next.
- `ena` and reset:
  - Stimulus: deassert `ena` for 5 cycles mid-message.
  - Response: outputs 0, message resumes intact afterwards.
  - Stimulus: assert `reset_n`=0 mid-message.
  - Response: all outputs 0 immediately; requester 0 wins the next arbitration.
